// File: rtl/fetch_pkg.sv
// Shared widths, constants and state encoding for the instruction fetch stage.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] pc_plus(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} words; flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  // Head is read straight from the array so a pushed word is visible one cycle later.
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  overflow_check: assert property (@(posedge clk) disable iff (!rst) !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response capture,
// prefetch FIFO toward the core, and redirect handling with stale-response discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SUM_W = CNT_W + 1;

  fetch_state_e            state_reg;
  logic [PC_W-1:0]         fetch_pc_reg, rsp_pc_reg;
  logic [CNT_W-1:0]        outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]        discard_reg, discard_next;
  logic [CNT_W-1:0]        fifo_count;
  logic [SUM_W-1:0]        credit_used;
  logic                    fifo_full, fifo_empty;
  logic                    req_fire, push, pop;
  logic [PC_W+INST_W-1:0]  head;

  // Outstanding plus buffered words never exceed DEPTH, so the FIFO cannot overflow.
  assign credit_used    = SUM_W'(outstanding_reg) + SUM_W'(fifo_count);
  assign imem_req_valid = rst && !fifo_full && (credit_used < SUM_W'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && (discard_reg == '0) && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_empty ? '0 : head[INST_W-1:0];
  assign inst_pc    = fifo_empty ? '0 : head[PC_W+INST_W-1:INST_W];

  always_comb begin
    outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    discard_next     = discard_reg;
    // A redirect marks everything still in flight as stale, including a same-cycle accept.
    if (redirect_valid)
      discard_next = outstanding_next;
    else if (imem_rsp_valid && (discard_reg != '0))
      discard_next = discard_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      state_reg       <= (discard_next != '0) ? DRAIN : RUN;
      if (redirect_valid) begin
        fetch_pc_reg <= redirect_pc;
        rsp_pc_reg   <= redirect_pc;
      end else begin
        if (req_fire) fetch_pc_reg <= pc_plus(fetch_pc_reg);
        if (push)     rsp_pc_reg   <= pc_plus(rsp_pc_reg);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({rsp_pc_reg, imem_rsp_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          n_req    = 0;
  logic [31:0] last_req_addr = '0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        found;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record an accepted request, then present any response now due.
  task automatic tick();
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
      last_req_addr = imem_req_addr;
      n_req++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend_addr.delete();
    pend_due.delete();
    n_req = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_first(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    // Reset values, before any clock edge
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_state", 32'(dut.state_reg), 32'(RUN));

    // Streaming, 1-cycle memory, core always ready
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int n = 0; n < 7; n++) begin
      tick();
      chk("t1_req_addr", last_req_addr, 32'(4 * n));
      if (n == 0) begin
        chk("t1_first_valid", 32'(inst_valid), 32'd0);
      end else begin
        chk("t1_inst_valid", 32'(inst_valid), 32'd1);
        chk("t1_inst_pc", inst_pc, 32'(4 * (n - 1)));
        chk("t1_inst_data", inst_data, word(32'(4 * (n - 1))));
      end
    end

    // Stall: credits exhausted after DEPTH requests, one pop frees one
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    chk("t2_n_req", 32'(n_req), 32'd4);
    chk("t2_last_addr", last_req_addr, 32'h0000_000C);
    chk("t2_req_valid_off", 32'(imem_req_valid), 32'd0);
    chk("t2_head_pc", inst_pc, 32'h0000_0000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t2_pc_after_pop", inst_pc, 32'h0000_0004);
    chk("t2_req_valid_on", 32'(imem_req_valid), 32'd1);
    chk("t2_req_addr", imem_req_addr, 32'h0000_0010);
    tick();
    chk("t2_n_req_after", 32'(n_req), 32'd5);
    chk("t2_new_addr", last_req_addr, 32'h0000_0010);
    chk("t2_req_valid_full", 32'(imem_req_valid), 32'd0);

    // Redirect with 3 outstanding, 3-cycle memory
    do_reset();
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    chk("t3_state_drain", 32'(dut.state_reg), 32'(DRAIN));
    chk("t3_discard", 32'(dut.discard_reg), 32'd2);
    chk("t3_req_addr", imem_req_addr, 32'h0000_0100);
    chk("t3_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("t3_still_drain", 32'(dut.state_reg), 32'(DRAIN));
    tick();
    chk("t3_state_run", 32'(dut.state_reg), 32'(RUN));
    wait_first(found);
    chk("t3_found", 32'(found), 32'd1);
    chk("t3_first_pc", inst_pc, 32'h0000_0100);
    chk("t3_first_data", inst_data, word(32'h0000_0100));

    // Redirect coinciding with a request accept and a response arrival
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    chk("t4_fifo_empty", 32'(inst_valid), 32'd0);
    chk("t4_discard", 32'(dut.discard_reg), 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h0000_0300);
    wait_first(found);
    chk("t4_found", 32'(found), 32'd1);
    chk("t4_first_pc", inst_pc, 32'h0000_0300);
    chk("t4_first_data", inst_data, word(32'h0000_0300));

    // Second redirect while still draining the first
    do_reset();
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("t5_discard_first", 32'(dut.discard_reg), 32'd3);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("t5_discard_reload", 32'(dut.discard_reg), 32'd3);
    chk("t5_state", 32'(dut.state_reg), 32'(DRAIN));
    wait_first(found);
    chk("t5_found", 32'(found), 32'd1);
    chk("t5_first_pc", inst_pc, 32'h0000_0200);
    chk("t5_first_data", inst_data, word(32'h0000_0200));

    // Asynchronous reset mid-burst with two words buffered
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    tick(); tick(); tick();
    chk("t6_pre_valid", 32'(inst_valid), 32'd1);
    chk("t6_pre_count", 32'(dut.u_fifo.count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_async_req_addr", imem_req_addr, 32'h0000_0000);
    imem_rsp_valid = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    n_req = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t6_restart_n_req", 32'(n_req), 32'd1);
    chk("t6_restart_addr", last_req_addr, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the SimpleRISC execute datapath. It replaces the combinational `pc -> instruction` lookup with a request/response handshake to instruction memory.
- Keeps up to DEPTH requests in flight and buffers returned words in a prefetch FIFO.
- Presents {instruction, pc} to the core with valid/ready.
- Handles taken-branch/call/ret redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DEPTH, 4: prefetch FIFO entries; also the cap on outstanding plus buffered words. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to clk.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  fetch byte address, word aligned.
- imem_rsp_valid  input  1  response word valid. Responses return in request order, latency of 1 or more cycles. Memory never back-pressures responses.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  core requests a PC change this cycle.
- redirect_pc  input  32  new fetch PC, word aligned.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  core consumes the head this cycle.
- inst_data  output  32  head instruction.
- inst_pc  output  32  PC of the head instruction.

Behaviour:
Reset values:
- All outputs are 0 while rst is low, except imem_req_addr, which is RESET_PC.
- fetch_pc = RESET_PC and rsp_pc = RESET_PC.
- outstanding = 0, discard = 0, FIFO empty, state = RUN.

Request issue:
- imem_req_valid = 1 when (outstanding + fifo_count) < DEPTH and rst is high.
- Once asserted, imem_req_valid and imem_req_addr hold until accepted.
- Exception: a redirect may change the address or drop the request in the same cycle.
- On accept (valid && ready): fetch_pc += 4 and outstanding += 1. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

Response path:
- Each response decrements outstanding.
- If discard > 0, the word is dropped and discard decrements.
- Otherwise {imem_rsp_data, rsp_pc} is written to the FIFO and rsp_pc += 4.
- The credit rule guarantees the FIFO never overflows. Overflow is a checked assertion.

Output:
- inst_valid = FIFO not empty; inst_data and inst_pc come from the FIFO head.
- The head pops when inst_valid && inst_ready.
- Push and pop may occur in the same cycle; a push into an empty FIFO appears on inst_valid the next cycle (1-cycle minimum response-to-output latency).

Redirect (highest priority):
- Takes effect in the cycle redirect_valid = 1.
- FIFO is flushed, including any same-cycle push. Any same-cycle pop is ignored.
- fetch_pc and rsp_pc are set to redirect_pc.
- discard = outstanding_next, where outstanding_next counts a request accepted in the redirect cycle as stale. It excludes a response arriving that cycle, because that response is itself dropped.
- imem_req_addr switches to redirect_pc from the next cycle.

State machine:
- RUN: discard == 0.
- DRAIN: discard > 0. New requests still issue during DRAIN.
- Transitions:
  - RUN -> DRAIN on a redirect with outstanding_next > 0.
  - DRAIN -> RUN when the last stale response is dropped.
  - Any redirect in DRAIN reloads discard.
- A redirect with nothing outstanding stays in RUN.

Simultaneous and stall cases:
- A response, an accepted request and a pop in one cycle each update their counters independently.
- inst_ready held low fills the FIFO; requests then stop until a pop frees a credit.

Reset mid-operation:
- All state clears immediately.
- Responses arriving after reset deassertion for pre-reset requests are unsupported. The memory must be reset together with this block.

Counter widths: outstanding, discard and fifo_count are each $clog2(DEPTH+1) bits.

Decomposition:
- Package fetch_pkg: INST_W = 32, PC_W = 32, PC_INC = 4, and the state enum {RUN, DRAIN}.
- Sub-module fetch_fifo: synchronous FIFO with DEPTH entries × 64 bits {pc, inst}. Ports are push, pop, flush, full, empty and count. It uses the same clk and active-low asynchronous rst.

Test Plan:
- Reset, then memory with 1-cycle latency and inst_ready = 1 -> requests to 0x0, 0x4, 0x8, …; inst_pc sequence 0x0, 0x4, 0x8 back-to-back at one per cycle after the first.
- inst_ready = 0, imem_req_ready = 1, DEPTH = 4 -> exactly 4 requests accepted (0x0–0xC), then imem_req_valid = 0. One pop -> one new request to 0x10.
- 3 requests outstanding (3-cycle latency), redirect_pc = 0x100 -> 3 stale responses dropped, state DRAIN -> RUN; first inst_pc out = 0x100 with the word returned for 0x100.
- Redirect in the same cycle as a request accept and a response arrival -> both words are discarded, and the FIFO is empty the next cycle; the next delivered inst_pc = redirect_pc.
- Second redirect to 0x200 during DRAIN from a redirect to 0x100 -> no 0x100-stream word ever reaches inst_*; first output pc = 0x200.
- Async reset asserted mid-burst with FIFO holding 2 words -> inst_valid = 0 and imem_req_valid = 0 immediately, without a clock edge. After release, the first request is to RESET_PC.
